// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving a simple dual-port block RAM.
// Zero-wait-state transfers, same-word read bypass, two-cycle ERROR.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [3:0]            bram_wea,
  output logic [31:0]           bram_dina,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_t;

  err_t state_q, state_d;

  logic                  accept;
  logic                  aligned;
  logic                  acc_ok;
  logic                  acc_bad;
  logic                  hazard;
  logic [3:0]            mask_d;
  logic [ADDR_WIDTH-1:0] waddr_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic                  wr_dp;
  logic                  rd_dp;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [31:0]           dina_q;
  logic                  byp_vld;
  logic [3:0]            byp_mask;
  logic [31:0]           byp_data;

  logic unused;
  assign unused = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign waddr_d = HADDR[ADDR_WIDTH+1:2];
  assign acc_ok  = accept & aligned;
  assign acc_bad = accept & ~aligned;

  always_comb begin
    aligned = 1'b0;
    mask_d  = 4'b0000;
    unique case (1'b1)
      HSIZE == 3'd0: begin
        aligned = 1'b1;
        mask_d  = 4'b0001 << HADDR[1:0];
      end
      HSIZE == 3'd1: begin
        aligned = ~HADDR[0];
        mask_d  = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE == 3'd2: begin
        aligned = (HADDR[1:0] == 2'b00);
        mask_d  = 4'b1111;
      end
      default: ;
    endcase
  end

  // RAM reads old data on a same-cycle write, so capture the write bytes
  assign hazard = acc_ok & ~HWRITE & wr_dp & (waddr_d == addr_q);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      mask_q   <= 4'b0000;
      wr_dp    <= 1'b0;
      rd_dp    <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
      byp_vld  <= 1'b0;
      byp_mask <= 4'b0000;
      byp_data <= '0;
    end else begin
      wr_dp   <= acc_ok & HWRITE;
      rd_dp   <= acc_ok & ~HWRITE;
      byp_vld <= hazard;
      if (acc_ok) begin
        addr_q <= waddr_d;
        mask_q <= mask_d;
      end
      if (wr_dp) begin
        addra_q <= addr_q;
        dina_q  <= HWDATA;
      end
      if (hazard) begin
        byp_mask <= bram_wea;
        byp_data <= HWDATA;
      end
    end
  end

  assign bram_addrb = waddr_d;
  assign bram_addra = wr_dp ? addr_q : addra_q;
  assign bram_wea   = wr_dp ? mask_q : 4'b0000;
  assign bram_dina  = wr_dp ? HWDATA : dina_q;

  always_comb begin
    HRDATA = '0;
    if (rd_dp) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[i*8 +: 8] = (byp_vld & byp_mask[i]) ?
                           byp_data[i*8 +: 8] :
                           bram_doutb[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_OK;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      ST_OK: begin
        if (acc_bad) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = 1'b1;
        state_d = acc_bad ? ST_ERR1 : ST_OK;
      end
      default: state_d = ST_OK;
    endcase
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a behavioural
// read-before-write block RAM model.
module tb_ahb_bram_ctrl;

  localparam int AW = 14;

  logic          HCLK;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          hready;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] bram_addra;
  logic [3:0]    bram_wea;
  logic [31:0]   bram_dina;
  logic [AW-1:0] bram_addrb;
  logic [31:0]   bram_doutb;

  int n_chk;
  int n_fail;

  logic [31:0] mem [0:(1<<AW)-1];

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (hready),
    .HREADYOUT  (hready),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .bram_addra (bram_addra),
    .bram_wea   (bram_wea),
    .bram_dina  (bram_dina),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (bram_wea[i])
        mem[bram_addra][i*8 +: 8] <= bram_dina[i*8 +: 8];
    bram_doutb <= mem[bram_addrb];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ap(input logic w, input logic [2:0] sz,
                    input logic [31:0] a);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = w;
    HSIZE  = sz;
    HADDR  = a;
  endtask

  task automatic idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'd2;
    HADDR  = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ap(1'b1, 3'd2, a);
    step();
    HWDATA = d;
    idle();
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    ap(1'b0, 3'd2, a);
    step();
    idle();
    #1;
    check(tag, HRDATA, exp);
    step();
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    HRESETn = 1'b0;
    HWDATA  = 32'h0;
    idle();
    #12;
    check("rst_hreadyout", {31'd0, hready}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    check("rst_wea", {28'd0, bram_wea}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_addra", {18'd0, bram_addra}, 32'd0);
    check("rst_dina", bram_dina, 32'd0);
    #5 HRESETn = 1'b1;
    step();

    wr(32'h44, 32'h8765_4321);
    wr(32'h00, 32'hA5A5_0FF0);
    wr(32'h80, 32'h1357_9BDF);

    // word write then read back
    ap(1'b1, 3'd2, 32'h10);
    step();
    HWDATA = 32'hDEAD_BEEF;
    idle();
    #1;
    check("t1_wea", {28'd0, bram_wea}, 32'hF);
    check("t1_addra", {18'd0, bram_addra}, 32'd4);
    check("t1_dina", bram_dina, 32'hDEAD_BEEF);
    check("t1_hrdata_wr", HRDATA, 32'd0);
    check("t1_hready", {31'd0, hready}, 32'd1);
    step();
    rd_chk("t1_read", 32'h10, 32'hDEAD_BEEF);

    // sub-word writes, read coincides with halfword data phase
    ap(1'b1, 3'd2, 32'h20);
    step();
    HWDATA = 32'h1122_3344;
    ap(1'b1, 3'd0, 32'h21);
    step();
    HWDATA = 32'h0000_AA00;
    ap(1'b1, 3'd1, 32'h22);
    #1;
    check("t2_wea_byte", {28'd0, bram_wea}, 32'h2);
    step();
    HWDATA = 32'h5566_0000;
    ap(1'b0, 3'd2, 32'h20);
    #1;
    check("t2_wea_half", {28'd0, bram_wea}, 32'hC);
    step();
    idle();
    #1;
    check("t2_read_byp", HRDATA, 32'h5566_AA44);
    step();
    rd_chk("t2_read", 32'h20, 32'h5566_AA44);

    // write immediately followed by read of same word
    ap(1'b1, 3'd2, 32'h40);
    step();
    HWDATA = 32'hCAFE_F00D;
    ap(1'b0, 3'd2, 32'h40);
    step();
    idle();
    #1;
    check("t3_bypass", HRDATA, 32'hCAFE_F00D);
    step();
    ap(1'b1, 3'd2, 32'h40);
    step();
    HWDATA = 32'h0BAD_F00D;
    ap(1'b0, 3'd2, 32'h44);
    step();
    idle();
    #1;
    check("t3_nobypass", HRDATA, 32'h8765_4321);
    step();
    rd_chk("t3_commit", 32'h40, 32'h0BAD_F00D);

    // unaligned word, then oversize transfer
    for (int k = 0; k < 2; k++) begin
      if (k == 0) ap(1'b1, 3'd2, 32'h02);
      else        ap(1'b1, 3'd3, 32'h00);
      step();
      HWDATA = 32'hFFFF_FFFF;
      idle();
      #1;
      check("t4_err1_ready", {31'd0, hready}, 32'd0);
      check("t4_err1_resp", {31'd0, HRESP}, 32'd1);
      check("t4_err1_wea", {28'd0, bram_wea}, 32'd0);
      check("t4_err1_rdata", HRDATA, 32'd0);
      step();
      check("t4_err2_ready", {31'd0, hready}, 32'd1);
      check("t4_err2_resp", {31'd0, HRESP}, 32'd1);
      check("t4_err2_wea", {28'd0, bram_wea}, 32'd0);
      step();
      check("t4_ok_resp", {31'd0, HRESP}, 32'd0);
      rd_chk("t4_read0", 32'h00, 32'hA5A5_0FF0);
    end

    // reset cutting a write data phase
    ap(1'b1, 3'd2, 32'h80);
    step();
    HWDATA = 32'hFFFF_0000;
    idle();
    #1;
    check("t5_wea_pre", {28'd0, bram_wea}, 32'hF);
    #1 HRESETn = 1'b0;
    #1;
    check("t5_wea_rst", {28'd0, bram_wea}, 32'd0);
    check("t5_dina_rst", bram_dina, 32'd0);
    check("t5_addra_rst", {18'd0, bram_addra}, 32'd0);
    check("t5_hready_rst", {31'd0, hready}, 32'd1);
    step();
    #2 HRESETn = 1'b1;
    step();
    rd_chk("t5_read", 32'h80, 32'h1357_9BDF);

    // address aliasing modulo RAM size
    wr(32'h0, 32'h1234_5678);
    ap(1'b0, 3'd2, 32'h1_0000);
    #1;
    check("t6_addrb", {18'd0, bram_addrb}, 32'd0);
    step();
    idle();
    #1;
    check("t6_alias", HRDATA, 32'h1234_5678);
    step();
    check("t6_idle_rdata", HRDATA, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
